// File: rtl/spi_cmd_sequencer.sv
// SPI mode-0 master: one 32-bit command word -> one CS-framed transfer (cmd, addr, data), MSB first.
// Accept -> cs_n low on the next cycle; ready only in IDLE, held words wait until the previous frame's GAP ends.
module spi_cmd_sequencer (
    input  logic        pclk_i,
    input  logic        prst_i,
    input  logic [31:0] cmd_data_i,
    input  logic        cmd_vld_i,
    output logic        cmd_rdy_o,
    input  logic [7:0]  clk_div_i,
    output logic        spi_sclk_o,
    output logic        spi_cs_n_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic [31:0] rx_data_o,
    output logic        rx_vld_o,
    output logic        busy_o,
    output logic        eot_o
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_h, r_cnt;
    logic [5:0]  r_bits_left, r_n;
    logic        r_rd;
    logic [23:0] r_tx;
    logic [31:0] r_rx_sh, r_rx_data;
    logic        r_sclk, r_cs_n, r_mosi, r_rdy, r_busy, r_eot, r_rx_vld;

    logic        w_accept, w_half_done, w_rise, w_fall, w_last_bit, w_hold_exit, w_data_phase;
    logic        w_wr;
    logic [7:0]  w_len, w_h;
    logic [5:0]  w_n;
    logic [15:0] w_wdata_al;
    logic [23:0] w_frame;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SHIFT;
            S_SHIFT: if (w_fall && w_last_bit) w_next = S_HOLD;
            S_HOLD:  if (w_half_done) w_next = S_GAP;
            S_GAP:   if (w_half_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept     = cmd_vld_i & r_rdy;
        w_half_done  = (r_cnt == r_h - 8'd1);
        w_rise       = (r_state == S_SHIFT) & ~r_sclk & w_half_done;
        w_fall       = (r_state == S_SHIFT) &  r_sclk & w_half_done;
        w_last_bit   = (r_bits_left == 6'd1);
        w_hold_exit  = (r_state == S_HOLD) & w_half_done;
        // Bits remaining counts down through the frame; the last N of them are data.
        w_data_phase = (r_bits_left <= r_n);
        w_wr         = cmd_data_i[31];
        w_len        = cmd_data_i[23:16];
        w_h          = (clk_div_i == 8'd0) ? 8'd1 : clk_div_i;
        if (w_wr) w_n = (w_len > 8'd16) ? 6'd16 : w_len[5:0];
        else      w_n = (w_len > 8'd32) ? 6'd32 : w_len[5:0];
        w_wdata_al = cmd_data_i[15:0] << (5'd16 - w_n[4:0]);
        w_frame    = {cmd_data_i[31:24], w_wr ? w_wdata_al : 16'h0000};
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_h         <= 8'd1;
            r_cnt       <= 8'd0;
            r_bits_left <= 6'd0;
            r_n         <= 6'd0;
            r_rd        <= 1'b0;
            r_tx        <= 24'd0;
            r_rx_sh     <= 32'd0;
            r_rx_data   <= 32'd0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b0;
            r_eot       <= 1'b0;
            r_rx_vld    <= 1'b0;
        end else begin
            r_rdy    <= (w_next == S_IDLE);
            r_eot    <= w_hold_exit;
            r_rx_vld <= w_hold_exit & r_rd;

            if (w_accept)   r_busy <= 1'b1;
            else if (r_eot) r_busy <= 1'b0;

            if (r_state == S_IDLE || w_half_done) r_cnt <= 8'd0;
            else                                   r_cnt <= r_cnt + 8'd1;

            if (w_accept) begin
                r_h         <= w_h;
                r_rd        <= ~w_wr;
                r_n         <= w_n;
                r_bits_left <= 6'd8 + w_n;
                r_mosi      <= w_frame[23];
                r_tx        <= {w_frame[22:0], 1'b0};
                r_rx_sh     <= 32'd0;
                r_cs_n      <= 1'b0;
                r_sclk      <= 1'b0;
            end

            if (w_rise) begin
                r_sclk <= 1'b1;
                if (r_rd && w_data_phase) r_rx_sh <= {r_rx_sh[30:0], spi_miso_i};
            end

            if (w_fall) begin
                r_sclk <= 1'b0;
                if (w_last_bit) begin
                    r_mosi <= 1'b0;
                end else begin
                    r_mosi      <= r_tx[23];
                    r_tx        <= {r_tx[22:0], 1'b0};
                    r_bits_left <= r_bits_left - 6'd1;
                end
            end

            if (w_hold_exit) begin
                r_cs_n <= 1'b1;
                if (r_rd) r_rx_data <= r_rx_sh;
            end
        end
    end

    assign cmd_rdy_o  = r_rdy;
    assign spi_sclk_o = r_sclk;
    assign spi_cs_n_o = r_cs_n;
    assign spi_mosi_o = r_mosi;
    assign rx_data_o  = r_rx_data;
    assign rx_vld_o   = r_rx_vld;
    assign busy_o     = r_busy;
    assign eot_o      = r_eot;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: each task runs one scenario and checks against hand-computed values.
module tb_spi_cmd_sequencer;
    logic        pclk_i = 1'b0;
    logic        prst_i = 1'b1;
    logic [31:0] cmd_data_i = 32'd0;
    logic        cmd_vld_i = 1'b0;
    logic        cmd_rdy_o;
    logic [7:0]  clk_div_i = 8'd2;
    logic        spi_sclk_o, spi_cs_n_o, spi_mosi_o;
    logic        spi_miso_i = 1'b0;
    logic [31:0] rx_data_o;
    logic        rx_vld_o, busy_o, eot_o;

    int checks = 0;
    int failures = 0;

    // Results captured by run_cmd for the calling task to judge.
    int          n_bits, hi_cyc, cs_low, eot_n, rxv_n, rxv_noneot, busy_err, mosi_rd_err, period;
    logic [63:0] cap;
    logic [31:0] rx_at_eot;
    logic        timeout;

    spi_cmd_sequencer dut (
        .pclk_i(pclk_i), .prst_i(prst_i), .cmd_data_i(cmd_data_i), .cmd_vld_i(cmd_vld_i),
        .cmd_rdy_o(cmd_rdy_o), .clk_div_i(clk_div_i), .spi_sclk_o(spi_sclk_o),
        .spi_cs_n_o(spi_cs_n_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
        .rx_data_o(rx_data_o), .rx_vld_o(rx_vld_o), .busy_o(busy_o), .eot_o(eot_o)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic run_cmd(input logic [31:0] word, input logic [7:0] div, input logic [7:0] div_after,
                           input logic rd, input int n, input logic [31:0] pat);
        logic prev_sclk, seen_eot, done;
        int   first_rise, w;
        n_bits = 0; hi_cyc = 0; cs_low = 0; eot_n = 0; rxv_n = 0; rxv_noneot = 0;
        busy_err = 0; mosi_rd_err = 0; period = 0; cap = 64'd0; rx_at_eot = 32'd0; timeout = 1'b0;
        prev_sclk = 1'b0; seen_eot = 1'b0; done = 1'b0; first_rise = 0;
        clk_div_i = div; cmd_data_i = word; cmd_vld_i = 1'b1; spi_miso_i = 1'b0;
        w = 0;
        while (!cmd_rdy_o && w < 200) begin @(posedge pclk_i); #1; w++; end
        if (!cmd_rdy_o) begin timeout = 1'b1; cmd_vld_i = 1'b0; return; end
        @(posedge pclk_i); #1;
        cmd_vld_i = 1'b0; clk_div_i = div_after;
        for (int c = 0; c < 5000; c++) begin
            if (!spi_cs_n_o) cs_low++;
            if (spi_sclk_o) hi_cyc++;
            if (spi_sclk_o && !prev_sclk) begin
                cap = {cap[62:0], spi_mosi_o};
                if (n_bits == 0) first_rise = c;
                if (n_bits == 1) period = c - first_rise;
                if (rd && n_bits >= 8 && spi_mosi_o) mosi_rd_err++;
                n_bits++;
            end
            if (busy_o !== !seen_eot) busy_err++;
            if (eot_o) begin eot_n++; rx_at_eot = rx_data_o; end
            if (rx_vld_o) begin rxv_n++; if (!eot_o) rxv_noneot++; end
            if (eot_o) seen_eot = 1'b1;
            prev_sclk = spi_sclk_o;
            if (rd && n_bits >= 8 && (n_bits - 8) < n) spi_miso_i = pat[n - 1 - (n_bits - 8)];
            else                                       spi_miso_i = 1'b0;
            if (seen_eot && cmd_rdy_o) begin done = 1'b1; break; end
            @(posedge pclk_i); #1;
        end
        if (!done) timeout = 1'b1;
    endtask

    task automatic test_reset();
        prst_i = 1'b1;
        repeat (3) @(posedge pclk_i);
        #1;
        checks++; if (spi_cs_n_o !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n_o); end
        checks++; if (spi_sclk_o !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b want 0", spi_sclk_o); end
        checks++; if (spi_mosi_o !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b want 0", spi_mosi_o); end
        checks++; if (cmd_rdy_o !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b want 0", cmd_rdy_o); end
        checks++; if ({busy_o, eot_o, rx_vld_o} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {busy_o, eot_o, rx_vld_o}); end
        checks++; if (rx_data_o !== 32'd0) begin failures++; $display("FAIL reset_rx_data: got %h want 0", rx_data_o); end
        prst_i = 1'b0;
        @(posedge pclk_i); #1;
        checks++; if (cmd_rdy_o !== 1'b1) begin failures++; $display("FAIL reset_release_rdy: got %b want 1", cmd_rdy_o); end
    endtask

    task automatic test_read();
        run_cmd(32'h120C_0000, 8'd2, 8'd2, 1'b1, 12, 32'h0000_0ABC);
        checks++; if (timeout) begin failures++; $display("FAIL read_timeout: got timeout want completion"); end
        checks++; if (n_bits != 20) begin failures++; $display("FAIL read_bits: got %0d want 20", n_bits); end
        checks++; if (cap !== 64'h12000) begin failures++; $display("FAIL read_mosi: got %h want 12000", cap); end
        checks++; if (mosi_rd_err != 0) begin failures++; $display("FAIL read_mosi_zero: got %0d ones want 0", mosi_rd_err); end
        checks++; if (rx_at_eot !== 32'h0000_0ABC) begin failures++; $display("FAIL read_rx_data: got %h want 00000abc", rx_at_eot); end
        checks++; if (eot_n != 1 || rxv_n != 1 || rxv_noneot != 0) begin failures++; $display("FAIL read_pulses: got eot=%0d rxv=%0d stray=%0d want 1 1 0", eot_n, rxv_n, rxv_noneot); end
        checks++; if (busy_err != 0) begin failures++; $display("FAIL read_busy: got %0d bad cycles want 0", busy_err); end
        checks++; if (cs_low != 82) begin failures++; $display("FAIL read_cs_low: got %0d want 82", cs_low); end
    endtask

    task automatic test_write();
        // clk_div_i is changed right after accept and must not disturb this frame.
        run_cmd(32'h8308_00A5, 8'd2, 8'd9, 1'b0, 8, 32'd0);
        checks++; if (timeout) begin failures++; $display("FAIL write_timeout: got timeout want completion"); end
        checks++; if (n_bits != 16) begin failures++; $display("FAIL write_bits: got %0d want 16", n_bits); end
        checks++; if (cap !== 64'h83A5) begin failures++; $display("FAIL write_mosi: got %h want 83a5", cap); end
        checks++; if (hi_cyc != 32 || period != 4) begin failures++; $display("FAIL write_sclk: got hi=%0d period=%0d want 32 4", hi_cyc, period); end
        checks++; if (cs_low != 66) begin failures++; $display("FAIL write_cs_low: got %0d want 66", cs_low); end
        checks++; if (eot_n != 1 || rxv_n != 0) begin failures++; $display("FAIL write_pulses: got eot=%0d rxv=%0d want 1 0", eot_n, rxv_n); end
        checks++; if (rx_data_o !== 32'h0000_0ABC) begin failures++; $display("FAIL write_rx_hold: got %h want 00000abc", rx_data_o); end
        checks++; if (busy_err != 0) begin failures++; $display("FAIL write_busy: got %0d bad cycles want 0", busy_err); end
    endtask

    task automatic test_len0();
        run_cmd(32'hA400_1234, 8'd3, 8'd3, 1'b0, 0, 32'd0);
        checks++; if (timeout) begin failures++; $display("FAIL len0_timeout: got timeout want completion"); end
        checks++; if (n_bits != 8 || cap !== 64'hA4) begin failures++; $display("FAIL len0_frame: got %0d bits %h want 8 a4", n_bits, cap); end
        checks++; if (cs_low != 51) begin failures++; $display("FAIL len0_cs_low: got %0d want 51", cs_low); end
    endtask

    task automatic test_write_clamp();
        run_cmd(32'hC614_BEEF, 8'd1, 8'd1, 1'b0, 16, 32'd0);
        checks++; if (timeout) begin failures++; $display("FAIL clamp_timeout: got timeout want completion"); end
        checks++; if (n_bits != 24 || cap !== 64'hC6BEEF) begin failures++; $display("FAIL clamp_frame: got %0d bits %h want 24 c6beef", n_bits, cap); end
        checks++; if (cs_low != 49) begin failures++; $display("FAIL clamp_cs_low: got %0d want 49", cs_low); end
    endtask

    task automatic test_div0();
        run_cmd(32'h9104_0005, 8'd0, 8'd0, 1'b0, 4, 32'd0);
        checks++; if (timeout) begin failures++; $display("FAIL div0_timeout: got timeout want completion"); end
        checks++; if (n_bits != 12 || cap !== 64'h915) begin failures++; $display("FAIL div0_frame: got %0d bits %h want 12 915", n_bits, cap); end
        checks++; if (period != 2 || hi_cyc != 12) begin failures++; $display("FAIL div0_sclk: got period=%0d hi=%0d want 2 12", period, hi_cyc); end
        checks++; if (cs_low != 25) begin failures++; $display("FAIL div0_cs_low: got %0d want 25", cs_low); end
    endtask

    task automatic test_back_to_back();
        int   accepts, eots, gap, rdy_err, frames_done;
        logic prev_cs, in_gap, done;
        accepts = 0; eots = 0; gap = 0; rdy_err = 0; frames_done = 0;
        prev_cs = 1'b1; in_gap = 1'b0; done = 1'b0;
        clk_div_i = 8'd3; cmd_data_i = 32'hA400_0000; cmd_vld_i = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (!spi_cs_n_o && cmd_rdy_o) rdy_err++;
            if (eot_o) eots++;
            if (spi_cs_n_o && !prev_cs) begin frames_done++; if (frames_done == 1) in_gap = 1'b1; end
            if (in_gap && spi_cs_n_o) gap++;
            if (in_gap && !spi_cs_n_o) in_gap = 1'b0;
            prev_cs = spi_cs_n_o;
            if (eots == 2 && cmd_rdy_o) begin done = 1'b1; break; end
            if (cmd_rdy_o && cmd_vld_i) begin
                @(posedge pclk_i); #1;
                accepts++;
                if (accepts == 1) cmd_data_i = 32'hF100_0000;
                else              cmd_vld_i = 1'b0;
            end else begin
                @(posedge pclk_i); #1;
            end
        end
        cmd_vld_i = 1'b0;
        checks++; if (!done) begin failures++; $display("FAIL b2b_timeout: got timeout want completion"); end
        checks++; if (accepts != 2 || eots != 2) begin failures++; $display("FAIL b2b_count: got acc=%0d eot=%0d want 2 2", accepts, eots); end
        checks++; if (gap != 4) begin failures++; $display("FAIL b2b_cs_gap: got %0d want 4", gap); end
        checks++; if (rdy_err != 0) begin failures++; $display("FAIL b2b_rdy_in_frame: got %0d want 0", rdy_err); end
    endtask

    task automatic test_reset_midframe();
        int   rises, stray;
        logic prev_sclk;
        rises = 0; stray = 0; prev_sclk = 1'b0;
        clk_div_i = 8'd2; cmd_data_i = 32'h120C_0000; cmd_vld_i = 1'b1;
        for (int c = 0; c < 500 && rises < 5; c++) begin
            @(posedge pclk_i); #1;
            if (!cmd_rdy_o) cmd_vld_i = 1'b0;
            if (spi_sclk_o && !prev_sclk) rises++;
            prev_sclk = spi_sclk_o;
        end
        cmd_vld_i = 1'b0;
        checks++; if (rises != 5) begin failures++; $display("FAIL rstmid_reach_bit5: got %0d rises want 5", rises); end
        prst_i = 1'b1;
        #1;
        checks++; if (spi_cs_n_o !== 1'b1 || spi_sclk_o !== 1'b0 || spi_mosi_o !== 1'b0) begin failures++; $display("FAIL rstmid_pins: got cs=%b sclk=%b mosi=%b want 1 0 0", spi_cs_n_o, spi_sclk_o, spi_mosi_o); end
        checks++; if (cmd_rdy_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl: got rdy=%b busy=%b want 0 0", cmd_rdy_o, busy_o); end
        checks++; if (rx_data_o !== 32'd0) begin failures++; $display("FAIL rstmid_rx_data: got %h want 0", rx_data_o); end
        for (int c = 0; c < 3; c++) begin
            @(posedge pclk_i); #1;
            if (eot_o || rx_vld_o) stray++;
        end
        prst_i = 1'b0;
        @(posedge pclk_i); #1;
        if (eot_o || rx_vld_o) stray++;
        checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_no_pulse: got %0d pulses want 0", stray); end
        checks++; if (cmd_rdy_o !== 1'b1) begin failures++; $display("FAIL rstmid_rdy: got %b want 1", cmd_rdy_o); end
        run_cmd(32'h120C_0000, 8'd2, 8'd2, 1'b1, 12, 32'h0000_05A5);
        checks++; if (timeout || rx_data_o !== 32'h0000_05A5 || eot_n != 1 || rxv_n != 1) begin failures++; $display("FAIL rstmid_recover: got rx=%h eot=%0d rxv=%0d to=%b want 000005a5 1 1 0", rx_data_o, eot_n, rxv_n, timeout); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_len0();
        test_write_clamp();
        test_div0();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
